// File: rtl/fifo_rd_stream.sv
// Read-side FIFO consumer: turns pop-then-data into a valid/ready stream
// through a 2-entry skid buffer and counts delivered words.
module fifo_rd_stream #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_pop,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  word_cnt
);

  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic              inflight_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [DATA_W-1:0] buf_q [2];
  logic [CNT_W-1:0]  cnt_q;

  logic       deq;
  logic       cap;
  logic [1:0] credit;

  assign deq = (occ_q != 2'd0) && m_ready;
  assign cap = inflight_q && !flush;

  // Slots already spoken for once this cycle's dequeue is accounted for.
  assign credit = occ_q + {1'b0, inflight_q} - {1'b0, deq};

  assign fifo_pop = !rst && !fifo_empty && !flush && (credit < 2'd2);

  assign occ_d = occ_q + {1'b0, cap} - {1'b0, deq};

  assign m_valid  = (occ_q != 2'd0);
  assign m_data   = buf_q[rd_ptr_q];
  assign word_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      cnt_q      <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      inflight_q <= fifo_pop;
      cnt_q      <= cnt_q + CNT_W'(deq);
      if (flush) begin
        occ_q    <= 2'd0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        occ_q    <= occ_d;
        rd_ptr_q <= rd_ptr_q ^ deq;
        wr_ptr_q <= wr_ptr_q ^ cap;
        if (cap) begin
          buf_q[wr_ptr_q] <= fifo_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO source model, word-queue scoreboard
// checked every cycle, plus directed literal expectations.
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data_out = '0;
  logic          fifo_pop;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          flush = 1'b0;
  logic [CW-1:0] word_cnt;

  fifo_rd_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_pop      (fifo_pop),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .flush         (flush),
    .word_cnt      (word_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src_q [$];
  logic [7:0] vis_q [$];
  logic [7:0] dlv_q [$];
  logic       pend_v = 1'b0;
  logic [7:0] pend_w = '0;
  int         mcnt = 0;
  int         cyc = 0;
  int         pops = 0;
  int         first_pop = -1;
  int         first_val = -1;
  int         dlv_first = -1;
  int         dlv_last = -1;

  bit ev;
  bit dq;
  bit ep;
  int cr;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Source FIFO: data_out valid the cycle after an accepted pop.
  always @(posedge clk) begin
    if (fifo_pop && src_q.size() != 0) begin
      fifo_data_out <= src_q[0];
      void'(src_q.pop_front());
      fifo_empty <= (src_q.size() == 0);
    end
  end

  // Scoreboard: deliverable words, one word in flight, delivered count.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_pop", 32'(fifo_pop), 0);
      chk("rst_valid", 32'(m_valid), 0);
      chk("rst_data", 32'(m_data), 0);
      chk("rst_cnt", 32'(word_cnt), 0);
      vis_q.delete();
      pend_v = 1'b0;
      mcnt = 0;
    end else begin
      ev = (vis_q.size() != 0);
      dq = ev && m_ready;
      cr = vis_q.size() + int'(pend_v) - int'(dq);
      ep = !fifo_empty && !flush && (cr < 2);
      chk("pop", 32'(fifo_pop), 32'(ep));
      chk("underflow", 32'(fifo_pop & fifo_empty), 0);
      chk("valid", 32'(m_valid), 32'(ev));
      if (ev) chk("data", 32'(m_data), 32'(vis_q[0]));
      chk("cnt", 32'(word_cnt), mcnt & 32'hFFFF);
      if (fifo_pop) begin
        pops++;
        if (first_pop < 0) first_pop = cyc;
      end
      if (m_valid && first_val < 0) first_val = cyc;
      if (dq) begin
        dlv_q.push_back(vis_q.pop_front());
        mcnt++;
        if (dlv_first < 0) dlv_first = cyc;
        dlv_last = cyc;
      end
      if (flush) vis_q.delete();
      else if (pend_v) vis_q.push_back(pend_w);
      pend_v = ep;
      if (ep) pend_w = src_q[0];
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(logic [7:0] w);
    src_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic drain(int maxc);
    int k;
    k = 0;
    while (!(fifo_empty && vis_q.size() == 0 && !pend_v) && k < maxc) begin
      tick();
      k++;
    end
    chk("drain_timeout", 32'(k >= maxc), 0);
  endtask

  logic [7:0] exp4 [4];
  int need;

  initial begin
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;

    // Reset and idle with an empty FIFO
    tick(3);
    rst = 1'b0;
    tick(5);
    chk("idle_pops", 32'(pops), 0);
    chk("idle_valid", 32'(m_valid), 0);
    chk("idle_cnt", 32'(word_cnt), 0);

    // Four-word burst, ready held high
    m_ready = 1'b1;
    first_pop = -1; first_val = -1; dlv_first = -1; dlv_last = -1;
    dlv_q.delete();
    for (int i = 0; i < 4; i++) push(exp4[i]);
    drain(20);
    chk("latency", 32'(first_val - first_pop), 2);
    chk("burst_span", 32'(dlv_last - dlv_first), 3);
    chk("burst_n", 32'(dlv_q.size()), 4);
    for (int i = 0; i < 4 && i < dlv_q.size(); i++)
      chk("burst_word", 32'(dlv_q[i]), 32'(exp4[i]));
    chk("burst_cnt", 32'(word_cnt), 4);

    // Back-pressure: only two pops, head held
    m_ready = 1'b0;
    dlv_q.delete();
    begin
      int p0;
      p0 = pops;
      for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
      tick(8);
      chk("bp_pops", 32'(pops - p0), 2);
    end
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_data", 32'(m_data), 32'hA0);
    tick(3);
    chk("bp_hold", 32'(m_data), 32'hA0);
    m_ready = 1'b1;
    drain(40);
    chk("bp_n", 32'(dlv_q.size()), 8);
    for (int i = 0; i < 8 && i < dlv_q.size(); i++)
      chk("bp_word", 32'(dlv_q[i]), 32'hA0 + 32'(i));
    chk("bp_cnt", 32'(word_cnt), 12);

    // Random ready, 200 words
    dlv_q.delete();
    for (int i = 0; i < 200; i++) push(8'((i * 37 + 5) & 255));
    for (int k = 0; k < 3000 && dlv_q.size() < 200; k++) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    m_ready = 1'b1;
    drain(10);
    chk("rnd_n", 32'(dlv_q.size()), 200);
    for (int i = 0; i < 200 && i < dlv_q.size(); i++)
      chk("rnd_word", 32'(dlv_q[i]), (i * 37 + 5) & 255);
    chk("rnd_cnt", 32'(word_cnt), 212);

    // Flush with a full buffer and a word in flight
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h51 + 8'(i));
    tick(6);
    chk("fl_head", 32'(m_data), 32'h51);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", 32'(m_valid), 0);
    chk("fl_cnt", 32'(word_cnt), 213);
    dlv_q.delete();
    m_ready = 1'b1;
    drain(30);
    chk("fl_n", 32'(dlv_q.size()), 3);
    if (dlv_q.size() > 0) chk("fl_next", 32'(dlv_q[0]), 32'h54);
    chk("fl_cnt2", 32'(word_cnt), 216);

    // Counter wrap
    dlv_q.delete();
    need = 65535 - mcnt;
    for (int i = 0; i < need; i++) push(8'(i));
    drain(70000);
    chk("cnt_max", 32'(word_cnt), 32'hFFFF);
    dlv_q.delete();
    push(8'h5A);
    drain(10);
    chk("cnt_wrap", 32'(word_cnt), 0);

    // Async reset mid-burst
    for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
    tick(4);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_pop", 32'(fifo_pop), 0);
    chk("arst_valid", 32'(m_valid), 0);
    chk("arst_data", 32'(m_data), 0);
    chk("arst_cnt", 32'(word_cnt), 0);
    src_q.delete();
    fifo_empty = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    chk("post_valid", 32'(m_valid), 0);
    chk("post_cnt", 32'(word_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
